// File: rtl/crossbar_pkg.sv
// Shared constants and direction encoding for the 5-port NoC crossbar.
package crossbar_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int NUM_PORTS  = 5;

   typedef enum logic [2:0] {
      DIR_N = 3'b000,
      DIR_S = 3'b001,
      DIR_W = 3'b010,
      DIR_E = 3'b011,
      DIR_L = 3'b100
   } dir_e;

   // Codes 3'b101..3'b111 name no port.
   function automatic logic sel_valid(logic [2:0] sel);
      return sel <= 3'b100;
   endfunction

endpackage

// File: rtl/crossbar_port_mux.sv
// One crossbar output column: gates each input onto this column when its demux
// select names this port, then picks the lane named by the column's mux select.
module crossbar_port_mux
   import crossbar_pkg::*;
#(
   parameter int   DATA_W = DATA_W_DEF,
   parameter dir_e MY_DIR = DIR_N
) (
   input  logic [DATA_W-1:0] in_n_i,
   input  logic [DATA_W-1:0] in_s_i,
   input  logic [DATA_W-1:0] in_w_i,
   input  logic [DATA_W-1:0] in_e_i,
   input  logic [DATA_W-1:0] in_l_i,
   input  logic [2:0]        dmx_n_i,
   input  logic [2:0]        dmx_s_i,
   input  logic [2:0]        dmx_w_i,
   input  logic [2:0]        dmx_e_i,
   input  logic [2:0]        dmx_l_i,
   input  logic [2:0]        sel_mux_i,
   output logic [DATA_W-1:0] out_o
);

   logic [DATA_W-1:0] lane_n, lane_s, lane_w, lane_e, lane_l;
   logic [DATA_W-1:0] picked;

   // Lanes into this column; an invalid demux code can never equal MY_DIR.
   always_comb begin
      lane_n = (dmx_n_i == MY_DIR) ? in_n_i : '0;
      lane_s = (dmx_s_i == MY_DIR) ? in_s_i : '0;
      lane_w = (dmx_w_i == MY_DIR) ? in_w_i : '0;
      lane_e = (dmx_e_i == MY_DIR) ? in_e_i : '0;
      lane_l = (dmx_l_i == MY_DIR) ? in_l_i : '0;
   end

   // Source selection; invalid mux codes yield zero.
   always_comb begin
      picked = '0;
      case (sel_mux_i)
         DIR_N:   picked = lane_n;
         DIR_S:   picked = lane_s;
         DIR_W:   picked = lane_w;
         DIR_E:   picked = lane_e;
         DIR_L:   picked = lane_l;
         default: picked = '0;
      endcase
      out_o = sel_valid(sel_mux_i) ? picked : '0;
   end

endmodule

// File: rtl/crossbar_switch_inner.sv
// 5-port router crossbar datapath with registered outputs.
// Build option CROSSBAR_INPUT_REG_EN adds a register stage on all data inputs
// and selects (latency 2 instead of 1); the port list is the same either way.
module crossbar_switch_inner
   import crossbar_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] n_cs_i,
   input  logic [DATA_W-1:0] s_cs_i,
   input  logic [DATA_W-1:0] w_cs_i,
   input  logic [DATA_W-1:0] e_cs_i,
   input  logic [DATA_W-1:0] l_cs_i,
   input  logic [2:0]        n_cs_sel_demux_i,
   input  logic [2:0]        s_cs_sel_demux_i,
   input  logic [2:0]        w_cs_sel_demux_i,
   input  logic [2:0]        e_cs_sel_demux_i,
   input  logic [2:0]        l_cs_sel_demux_i,
   input  logic [2:0]        n_cs_sel_mux_i,
   input  logic [2:0]        s_cs_sel_mux_i,
   input  logic [2:0]        w_cs_sel_mux_i,
   input  logic [2:0]        e_cs_sel_mux_i,
   input  logic [2:0]        l_cs_sel_mux_i,
   output logic [DATA_W-1:0] n_cs_o,
   output logic [DATA_W-1:0] s_cs_o,
   output logic [DATA_W-1:0] w_cs_o,
   output logic [DATA_W-1:0] e_cs_o,
   output logic [DATA_W-1:0] l_cs_o
);

   logic [DATA_W-1:0] in_d  [NUM_PORTS];
   logic [2:0]        dmx_d [NUM_PORTS];
   logic [2:0]        mux_d [NUM_PORTS];

   logic [DATA_W-1:0] xin   [NUM_PORTS];
   logic [2:0]        xdmx  [NUM_PORTS];
   logic [2:0]        xmux  [NUM_PORTS];

   logic [DATA_W-1:0] out_d [NUM_PORTS];
   logic [DATA_W-1:0] out_q [NUM_PORTS];

   // Gather ports into arrays indexed by direction code.
   always_comb begin
      in_d[0]  = n_cs_i;            in_d[1]  = s_cs_i;
      in_d[2]  = w_cs_i;            in_d[3]  = e_cs_i;
      in_d[4]  = l_cs_i;
      dmx_d[0] = n_cs_sel_demux_i;  dmx_d[1] = s_cs_sel_demux_i;
      dmx_d[2] = w_cs_sel_demux_i;  dmx_d[3] = e_cs_sel_demux_i;
      dmx_d[4] = l_cs_sel_demux_i;
      mux_d[0] = n_cs_sel_mux_i;    mux_d[1] = s_cs_sel_mux_i;
      mux_d[2] = w_cs_sel_mux_i;    mux_d[3] = e_cs_sel_mux_i;
      mux_d[4] = l_cs_sel_mux_i;
   end

`ifdef CROSSBAR_INPUT_REG_EN
   logic [DATA_W-1:0] in_q  [NUM_PORTS];
   logic [2:0]        dmx_q [NUM_PORTS];
   logic [2:0]        mux_q [NUM_PORTS];

   // Input stage: flits and selects captured together so they stay aligned.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            in_q[p]  <= '0;
            dmx_q[p] <= '0;
            mux_q[p] <= '0;
         end
      end else begin
         in_q  <= in_d;
         dmx_q <= dmx_d;
         mux_q <= mux_d;
      end
   end

   // Crossbar fed from the input stage.
   always_comb begin
      xin  = in_q;
      xdmx = dmx_q;
      xmux = mux_q;
   end
`else
   // Crossbar fed straight from the ports.
   always_comb begin
      xin  = in_d;
      xdmx = dmx_d;
      xmux = mux_d;
   end
`endif

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_col
      crossbar_port_mux #(
         .DATA_W (DATA_W),
         .MY_DIR (dir_e'(3'(p)))
      ) u_col (
         .in_n_i    (xin[0]),
         .in_s_i    (xin[1]),
         .in_w_i    (xin[2]),
         .in_e_i    (xin[3]),
         .in_l_i    (xin[4]),
         .dmx_n_i   (xdmx[0]),
         .dmx_s_i   (xdmx[1]),
         .dmx_w_i   (xdmx[2]),
         .dmx_e_i   (xdmx[3]),
         .dmx_l_i   (xdmx[4]),
         .sel_mux_i (xmux[p]),
         .out_o     (out_d[p])
      );
   end

   // Output registers; reset discards any in-flight flit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign n_cs_o = out_q[0];
   assign s_cs_o = out_q[1];
   assign w_cs_o = out_q[2];
   assign e_cs_o = out_q[3];
   assign l_cs_o = out_q[4];

endmodule

// File: tb/tb_crossbar_switch_inner.sv
// Randomized + directed bench for crossbar_switch_inner against a route-table model.
module tb_crossbar_switch_inner;

`ifdef CROSSBAR_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] din  [5];
   logic [2:0]  dmx  [5];
   logic [2:0]  mux  [5];
   logic [15:0] dout [5];

   logic [15:0] pipe [LAT][5];
   int          n_tests = 0;
   int          n_fail  = 0;
   string       pname [5] = '{"n", "s", "w", "e", "l"};

   always #5 clk_i = ~clk_i;

   crossbar_switch_inner dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .n_cs_i           (din[0]),
      .s_cs_i           (din[1]),
      .w_cs_i           (din[2]),
      .e_cs_i           (din[3]),
      .l_cs_i           (din[4]),
      .n_cs_sel_demux_i (dmx[0]),
      .s_cs_sel_demux_i (dmx[1]),
      .w_cs_sel_demux_i (dmx[2]),
      .e_cs_sel_demux_i (dmx[3]),
      .l_cs_sel_demux_i (dmx[4]),
      .n_cs_sel_mux_i   (mux[0]),
      .s_cs_sel_mux_i   (mux[1]),
      .w_cs_sel_mux_i   (mux[2]),
      .e_cs_sel_mux_i   (mux[3]),
      .l_cs_sel_mux_i   (mux[4]),
      .n_cs_o           (dout[0]),
      .s_cs_o           (dout[1]),
      .w_cs_o           (dout[2]),
      .e_cs_o           (dout[3]),
      .l_cs_o           (dout[4])
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Output dst carries input src only when src is a real port, src routes to dst,
   // and dst selects src.
   function automatic logic [15:0] ref_out(int dst);
      int src;
      src = int'(mux[dst]);
      if (src > 4) return 16'h0;
      if (int'(dmx[src]) != dst) return 16'h0;
      return din[src];
   endfunction

   // One clock: advance the model, then compare all five outputs mid-cycle.
   task automatic cycle(input string tag);
      logic [15:0] nxt [5];
      for (int d = 0; d < 5; d++) nxt[d] = rst_i ? 16'h0 : ref_out(d);
      @(posedge clk_i);
      if (rst_i) begin
         for (int s = 0; s < LAT; s++)
            for (int d = 0; d < 5; d++) pipe[s][d] = 16'h0;
      end else begin
         for (int s = LAT - 1; s > 0; s--) pipe[s] = pipe[s-1];
         pipe[0] = nxt;
      end
      @(negedge clk_i);
      for (int d = 0; d < 5; d++) check({tag, "_", pname[d]}, dout[d], pipe[LAT-1][d]);
   endtask

   task automatic set_route(input logic [14:0] dm, input logic [14:0] mx);
      for (int p = 0; p < 5; p++) begin
         dmx[p] = dm[14-3*p -: 3];
         mux[p] = mx[14-3*p -: 3];
      end
   endtask

   task automatic set_onehot_inputs();
      for (int p = 0; p < 5; p++) din[p] = 16'(1 << p);
   endtask

   initial begin
      logic [15:0] hist [$];
      for (int p = 0; p < 5; p++) begin
         din[p] = 16'h0; dmx[p] = 3'b000; mux[p] = 3'b000;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      repeat (3) cycle("reset");

      // Straight and turn paths (order N,S,W,E,L).
      rst_i = 1'b0;
      set_onehot_inputs();
      set_route({3'b100, 3'b000, 3'b000, 3'b000, 3'b000},
                {3'b100, 3'b000, 3'b001, 3'b010, 3'b000});
      repeat (LAT) cycle("turn");
      check("turn_n_const", dout[0], 16'h0010);
      check("turn_l_const", dout[4], 16'h0001);
      check("turn_s_const", dout[1], 16'h0000);

      // Full agreement.
      set_route({3'b001, 3'b000, 3'b011, 3'b010, 3'b100},
                {3'b001, 3'b000, 3'b011, 3'b010, 3'b100});
      repeat (LAT) cycle("agree");
      check("agree_n_const", dout[0], 16'h0002);
      check("agree_s_const", dout[1], 16'h0001);
      check("agree_w_const", dout[2], 16'h0008);
      check("agree_e_const", dout[3], 16'h0004);
      check("agree_l_const", dout[4], 16'h0010);

      // Select mismatch.
      set_route({3'b100, 3'b100, 3'b100, 3'b100, 3'b000},
                {3'b100, 3'b000, 3'b000, 3'b000, 3'b000});
      repeat (LAT) cycle("mism");
      check("mism_n_const", dout[0], 16'h0010);
      check("mism_w_const", dout[2], 16'h0000);
      check("mism_l_const", dout[4], 16'h0001);

      // Invalid codes.
      for (int p = 0; p < 5; p++) begin
         din[p] = 16'hA5A5 ^ 16'(p); dmx[p] = 3'b111; mux[p] = 3'b101;
      end
      repeat (LAT) cycle("inval");
      for (int d = 0; d < 5; d++) check({"inval_const_", pname[d]}, dout[d], 16'h0);

      // Reset mid-traffic, route N->S.
      set_route({3'b001, 3'b111, 3'b111, 3'b111, 3'b111},
                {3'b111, 3'b000, 3'b111, 3'b111, 3'b111});
      din[0] = 16'hBEEF;
      repeat (LAT) cycle("pre_rst");
      check("pre_rst_s_const", dout[1], 16'hBEEF);
      rst_i = 1'b1;
      cycle("rst");
      check("rst_s_const", dout[1], 16'h0000);
      rst_i = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         cycle("post_rst");
         if (i < LAT - 1) check("post_rst_s_early", dout[1], 16'h0000);
      end
      check("post_rst_s_const", dout[1], 16'hBEEF);

      // Latency: s_cs_o follows n_cs_i delayed LAT cycles.
      for (int i = 0; i < 20; i++) begin
         din[0] = 16'($urandom);
         hist.push_back(din[0]);
         cycle("lat");
         if (i >= LAT - 1) check("lat_s_delay", dout[1], hist[i-LAT+1]);
      end

      // Random traffic, biased towards agreeing selects, with occasional reset.
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 5; p++) begin
            din[p] = 16'($urandom);
            dmx[p] = 3'($urandom_range(0, 7));
            mux[p] = 3'($urandom_range(0, 7));
         end
         for (int d = 0; d < 5; d++) begin
            if ($urandom_range(0, 1) == 1) begin
               int s;
               s = $urandom_range(0, 4);
               mux[d] = 3'(s);
               dmx[s] = 3'(d);
            end
         end
         rst_i = ($urandom_range(0, 19) == 0);
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
